// File: rtl/ar_issue.sv
// AR issue stage: registers translated read requests, splits INCR bursts at 4 KB and paces AXI ARs with a credit counter.
// Optional statistics counters are enabled by defining AR_ISSUE_STATS_EN.
module ar_issue #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [79:0] ar,
    input  logic        ar_valid,
    output logic        ar_ready,
    output logic [3:0]  m_axi_arid,
    output logic [47:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic        m_axi_rvalid,
    input  logic        m_axi_rready,
    input  logic        m_axi_rlast,
    output logic [7:0]  outstanding,
    output logic        err_underflow
`ifdef AR_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_split
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HOLD_A = 3'd1;
    localparam logic [2:0] SEND_A = 3'd2;
    localparam logic [2:0] HOLD_B = 3'd3;
    localparam logic [2:0] SEND_B = 3'd4;

    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    logic [2:0]  state;
    logic        split_q;
    logic [47:0] addr_b_q;
    logic [7:0]  len_b_q;

    // Request word decode; the low four address bits are always zero.
    logic [3:0]  req_id;
    logic [47:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic        unused_rsv;

    assign req_id     = ar[3:0];
    assign req_addr   = {ar[47:4], 4'h0};
    assign req_len    = ar[55:48];
    assign req_size   = ar[58:56];
    assign req_burst  = ar[60:59];
    assign unused_rsv = ^ar[79:61];

    // Split decision: only INCR bursts with a legal beat size that overrun the current 4 KB page.
    logic [15:0] req_bytes;
    logic [12:0] req_room;
    logic [12:0] room_beats;
    logic        req_split;
    logic [7:0]  req_len_a;
    logic [47:0] req_addr_b;
    logic [7:0]  req_len_b;

    assign req_bytes  = ({8'd0, req_len} + 16'd1) << req_size;
    assign req_room   = 13'h1000 - {1'b0, req_addr[11:0]};
    assign room_beats = req_room >> req_size;
    assign req_split  = (req_burst == 2'b01) && (req_size <= 3'd4) &&
                        (req_bytes > {3'b000, req_room});
    assign req_len_a  = req_split ? 8'(room_beats - 13'd1) : req_len;
    assign req_addr_b = (req_addr | 48'h0000_0000_0FFF) + 48'd1;
    assign req_len_b  = req_len - req_len_a - 8'd1;

    logic credit_ok;
    logic ar_hs;
    logic r_done;
    logic accept;

    assign credit_ok     = (outstanding < MAX_OUT);
    assign ar_hs         = m_axi_arvalid & m_axi_arready;
    assign r_done        = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign ar_ready      = reset_n & (state == IDLE);
    assign accept        = ar_valid & ar_ready;
    assign m_axi_arvalid = (state == SEND_A) || (state == SEND_B);

    // Control and AR payload registers; payload only changes while arvalid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state is written with non-blocking assignments only, so every
            // register samples the pre-edge values regardless of statement order.
            state         <= IDLE;
            split_q       <= 1'b0;
            addr_b_q      <= '0;
            len_b_q       <= '0;
            m_axi_arid    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_axi_arid    <= req_id;
                        m_axi_araddr  <= req_addr;
                        m_axi_arlen   <= req_len_a;
                        m_axi_arsize  <= req_size;
                        m_axi_arburst <= req_burst;
                        split_q       <= req_split;
                        addr_b_q      <= req_addr_b;
                        len_b_q       <= req_len_b;
                        state         <= credit_ok ? SEND_A : HOLD_A;
                    end
                end
                HOLD_A: begin
                    if (credit_ok) state <= SEND_A;
                end
                SEND_A: begin
                    if (m_axi_arready) begin
                        if (split_q) begin
                            m_axi_araddr <= addr_b_q;
                            m_axi_arlen  <= len_b_q;
                            state        <= HOLD_B;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD_B: begin
                    if (credit_ok) state <= SEND_B;
                end
                SEND_B: begin
                    if (m_axi_arready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit counter: issue and completion in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (r_done && (outstanding == 8'd0)) err_underflow <= 1'b1;
            if (ar_hs && !r_done) begin
                outstanding <= outstanding + 8'd1;
            end else if (r_done && !ar_hs && (outstanding != 8'd0)) begin
                outstanding <= outstanding - 8'd1;
            end
        end
    end

`ifdef AR_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued <= '0;
            stat_split  <= '0;
        end else begin
            if (ar_hs) stat_issued <= stat_issued + 32'd1;
            if (accept && req_split) stat_split <= stat_split + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ar_issue.sv
// Self-checking bench for ar_issue: split-rule vector table, directed credit/backpressure/reset
// sequences and a randomized run against a transaction-level reference model.
module tb_ar_issue;

    localparam int MAXO = 2;

    logic        clk;
    logic        reset_n;
    logic [79:0] ar;
    logic        ar_valid;
    logic        ar_ready;
    logic [3:0]  m_axi_arid;
    logic [47:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        m_axi_rlast;
    logic [7:0]  outstanding;
    logic        err_underflow;

    ar_issue #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ar            (ar),
        .ar_valid      (ar_valid),
        .ar_ready      (ar_ready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rlast   (m_axi_rlast),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    typedef struct {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          exp_n;
        logic [47:0] a_addr;
        logic [7:0]  a_len;
        logic [47:0] b_addr;
        logic [7:0]  b_len;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] pack(input ar_t r);
        logic [18:0] rsv;
        rsv = 19'($urandom());
        return {rsv, r.burst, r.size, r.len, r.addr[47:4], r.id};
    endfunction

    task automatic set_r(input logic v);
        m_axi_rvalid = v;
        m_axi_rready = v;
        m_axi_rlast  = v;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic accept_req(input ar_t r);
        ar       = pack(r);
        ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
    endtask

    // Reference split rule, written straight from the byte/room arithmetic.
    task automatic model_split(input ar_t r, output ar_t a, output ar_t b, output bit two);
        int bytes;
        int room;
        bytes = (int'(r.len) + 1) << r.size;
        room  = 4096 - int'(r.addr[11:0]);
        two   = (r.burst == 2'b01) && (r.size <= 3'd4) && (bytes > room);
        a = r;
        b = r;
        if (two) begin
            a.len  = 8'((room >> r.size) - 1);
            b.addr = (r.addr | 48'hFFF) + 48'd1;
            b.len  = r.len - a.len - 8'd1;
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        ar_t r;
        int  n;
        r = '{v.id, v.addr, v.len, v.size, v.burst};
        m_axi_arready = 1'b1;
        check($sformatf("vec%0d_ar_ready", k), ar_ready, 1'b1);
        accept_req(r);
        check($sformatf("vec%0d_latency", k), m_axi_arvalid, 1'b1);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_axi_arvalid) begin
                check($sformatf("vec%0d_idszb", k), {m_axi_arid, m_axi_arsize, m_axi_arburst},
                      {v.id, v.size, v.burst});
                check($sformatf("vec%0d_addr%0d", k, n), m_axi_araddr, (n == 0) ? v.a_addr : v.b_addr);
                check($sformatf("vec%0d_len%0d", k, n), m_axi_arlen, (n == 0) ? v.a_len : v.b_len);
                n++;
            end
            tick();
        end
        check($sformatf("vec%0d_count", k), n, v.exp_n);
        check($sformatf("vec%0d_out", k), outstanding, v.exp_n);
        set_r(1'b1);
        repeat (v.exp_n) tick();
        set_r(1'b0);
        check($sformatf("vec%0d_drain", k), outstanding, 0);
    endtask

    vec_t vecs[10];
    ar_t  exp_q[$];

    initial begin
        ar_t  r;
        ar_t  pa;
        ar_t  pb;
        bit   two;
        int   m_out;
        int   m_out_pre;
        logic prev_v;
        logic prev_rdy;
        ar_t  prev_f;
        logic lat_chk;
        logic lat_exp;

        reset_n       = 1'b0;
        ar            = '0;
        ar_valid      = 1'b0;
        m_axi_arready = 1'b0;
        set_r(1'b0);

        vecs[0] = '{4'h1, 48'h0000_1000_0000, 8'd15, 3'd4, 2'b01, 1, 48'h0000_1000_0000, 8'd15, 48'h0, 8'd0};
        vecs[1] = '{4'h2, 48'h0000_1000_0F80, 8'd15, 3'd4, 2'b01, 2, 48'h0000_1000_0F80, 8'd7, 48'h0000_1000_1000, 8'd7};
        vecs[2] = '{4'h3, 48'h0000_2000_0F00, 8'd15, 3'd4, 2'b01, 1, 48'h0000_2000_0F00, 8'd15, 48'h0, 8'd0};
        vecs[3] = '{4'h4, 48'h0000_1000_0F80, 8'd15, 3'd4, 2'b00, 1, 48'h0000_1000_0F80, 8'd15, 48'h0, 8'd0};
        vecs[4] = '{4'h5, 48'h0000_1000_0F80, 8'd15, 3'd4, 2'b10, 1, 48'h0000_1000_0F80, 8'd15, 48'h0, 8'd0};
        vecs[5] = '{4'h6, 48'h0000_0000_0FF0, 8'd31, 3'd0, 2'b01, 2, 48'h0000_0000_0FF0, 8'd15, 48'h0000_0000_1000, 8'd15};
        vecs[6] = '{4'h7, 48'h0000_0000_0FF0, 8'd0,  3'd5, 2'b01, 1, 48'h0000_0000_0FF0, 8'd0, 48'h0, 8'd0};
        vecs[7] = '{4'h8, 48'h0000_ABCD_EFC0, 8'd255, 3'd2, 2'b01, 2, 48'h0000_ABCD_EFC0, 8'd15, 48'h0000_ABCD_F000, 8'd239};
        vecs[8] = '{4'h9, 48'hFFFF_FFFF_FFF0, 8'd1,  3'd4, 2'b01, 2, 48'hFFFF_FFFF_FFF0, 8'd0, 48'h0000_0000_0000, 8'd0};
        vecs[9] = '{4'hA, 48'h0000_1000_0F80, 8'd15, 3'd4, 2'b11, 1, 48'h0000_1000_0F80, 8'd15, 48'h0, 8'd0};

        // Reset state.
        #12;
        check("rst_ar_ready_low", ar_ready, 1'b0);
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        #10 reset_n = 1'b1;
        tick();
        check("rst_ar_ready", ar_ready, 1'b1);
        check("rst_out", outstanding, 0);
        check("rst_err", err_underflow, 1'b0);
        check("rst_addr_len", {m_axi_araddr, m_axi_arlen}, 56'd0);

        for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

        // Credit limit with MAX_OUTSTANDING=2.
        m_axi_arready = 1'b1;
        r = '{4'h1, 48'h0000_3000_0000, 8'd3, 3'd4, 2'b01};
        accept_req(r);
        tick();
        r.addr = 48'h0000_3000_0100;
        accept_req(r);
        tick();
        check("cred_out_full", outstanding, 2);
        r.addr = 48'h0000_3000_0200;
        accept_req(r);
        for (int i = 0; i < 3; i++) begin
            check("cred_held", m_axi_arvalid, 1'b0);
            check("cred_ready_low", ar_ready, 1'b0);
            tick();
        end
        set_r(1'b1);
        tick();
        set_r(1'b0);
        check("cred_released", outstanding, 1);
        check("cred_not_yet", m_axi_arvalid, 1'b0);
        tick();
        check("cred_issue", m_axi_arvalid, 1'b1);
        check("cred_addr", m_axi_araddr, 48'h0000_3000_0200);
        tick();
        check("cred_out_after", outstanding, 2);
        set_r(1'b1);
        repeat (2) tick();
        set_r(1'b0);
        check("cred_drain", outstanding, 0);

        // Simultaneous issue and completion, then underflow.
        r = '{4'h3, 48'h0000_4000_0000, 8'd0, 3'd3, 2'b01};
        accept_req(r);
        tick();
        accept_req(r);
        set_r(1'b1);
        tick();
        set_r(1'b0);
        check("simul_out", outstanding, 1);
        check("simul_done", m_axi_arvalid, 1'b0);
        set_r(1'b1);
        tick();
        set_r(1'b0);
        check("simul_drain", outstanding, 0);
        check("err_clear_before", err_underflow, 1'b0);
        set_r(1'b1);
        tick();
        set_r(1'b0);
        check("underflow_err", err_underflow, 1'b1);
        check("underflow_out", outstanding, 0);
        tick();
        check("underflow_sticky", err_underflow, 1'b1);
        do_reset();
        check("underflow_reset", err_underflow, 1'b0);

        // Randomized run against the transaction-level model.
        exp_q.delete();
        m_out    = 0;
        prev_v   = 1'b0;
        prev_rdy = 1'b0;
        prev_f   = '{4'h0, 48'h0, 8'h0, 3'h0, 2'h0};
        lat_chk  = 1'b0;
        lat_exp  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_ar_ready", ar_ready, exp_q.size() == 0);
            check("rnd_out", outstanding, m_out);
            if (lat_chk) check("rnd_latency", m_axi_arvalid, lat_exp);
            if (prev_v && !prev_rdy) begin
                check("rnd_hold_valid", m_axi_arvalid, 1'b1);
                check("rnd_hold_addr", m_axi_araddr, prev_f.addr);
                check("rnd_hold_len", m_axi_arlen, prev_f.len);
            end
            if (m_axi_arvalid) check("rnd_ar_expected", exp_q.size() != 0, 1'b1);

            m_axi_arready = ($urandom_range(0, 3) != 0);
            ar_valid      = ($urandom_range(0, 1) == 1);
            r.id    = 4'($urandom());
            r.addr  = {16'($urandom()), 20'($urandom()), 12'h000};
            r.addr[11:0] = ($urandom_range(0, 1) == 1) ? (12'hF00 | 12'($urandom_range(0, 255))) & 12'hFF0
                                                       : 12'($urandom()) & 12'hFF0;
            r.len   = 8'($urandom());
            r.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            r.burst = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b01;
            ar      = pack(r);
            m_axi_rvalid = ($urandom_range(0, 2) != 0);
            m_axi_rready = ($urandom_range(0, 2) != 0);
            m_axi_rlast  = (m_out > 0) && ($urandom_range(0, 1) == 1);

            m_out_pre = m_out;
            if (m_axi_arvalid && m_axi_arready && exp_q.size() != 0) begin
                check("rnd_credit", m_out < MAXO, 1'b1);
                check("rnd_idszb", {m_axi_arid, m_axi_arsize, m_axi_arburst},
                      {exp_q[0].id, exp_q[0].size, exp_q[0].burst});
                check("rnd_addr", m_axi_araddr, exp_q[0].addr);
                check("rnd_len", m_axi_arlen, exp_q[0].len);
                void'(exp_q.pop_front());
            end
            if ((m_axi_arvalid && m_axi_arready) && !(m_axi_rvalid && m_axi_rready && m_axi_rlast))
                m_out++;
            else if (!(m_axi_arvalid && m_axi_arready) && (m_axi_rvalid && m_axi_rready && m_axi_rlast))
                m_out--;
            lat_chk = ar_valid && ar_ready;
            lat_exp = (m_out_pre < MAXO);
            if (ar_valid && ar_ready) begin
                model_split(r, pa, pb, two);
                exp_q.push_back(pa);
                if (two) exp_q.push_back(pb);
            end
            prev_v   = m_axi_arvalid;
            prev_rdy = m_axi_arready;
            prev_f   = '{m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst};
            tick();
        end
        ar_valid      = 1'b0;
        m_axi_arready = 1'b0;
        set_r(1'b0);
        check("rnd_no_err", err_underflow, 1'b0);

        // Backpressure on a split request, then async reset while piece B is pending.
        do_reset();
        r = '{4'h5, 48'h0000_1000_0F80, 8'd15, 3'd4, 2'b01};
        accept_req(r);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", m_axi_arvalid, 1'b1);
            check("bp_addr", m_axi_araddr, 48'h0000_1000_0F80);
            check("bp_len", m_axi_arlen, 8'd7);
            check("bp_ready", ar_ready, 1'b0);
            tick();
        end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        check("bp_hold_b", m_axi_arvalid, 1'b0);
        check("bp_out", outstanding, 1);
        check("bp_ready_b", ar_ready, 1'b0);
        tick();
        check("bp_send_b", m_axi_arvalid, 1'b1);
        check("bp_addr_b", m_axi_araddr, 48'h0000_1000_1000);
        check("bp_len_b", m_axi_arlen, 8'd7);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", m_axi_arvalid, 1'b0);
        check("arst_ready", ar_ready, 1'b0);
        check("arst_out", outstanding, 0);
        #3 reset_n = 1'b1;
        tick();
        check("arst_idle_ready", ar_ready, 1'b1);
        check("arst_idle_out", outstanding, 0);
        check("arst_idle_valid", m_axi_arvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ar_issue.md
Name: ar_issue

Overview:
- Downstream stage of the AR address-translation stage in the DoCE transaction layer.
- Consumes the translated 80-bit read-request word and drives an AXI4 master AR channel toward the local memory interconnect.
- Splits INCR bursts that cross a 4 KB boundary into two AXI transactions.
- Limits outstanding AXI reads with a credit counter that is released on observed R-channel last beats.

Parameters:
MAX_OUTSTANDING, 8, maximum issued-but-uncompleted AXI read transactions (1..255)

Ports:
clk  input  1  single clock
reset_n  input  1  asynchronous, active-low reset
ar  input  80  request word: [3:0] ARID, [47:4] ARADDR[47:4] (ARADDR[3:0]=0), [55:48] ARLEN, [58:56] ARSIZE, [60:59] ARBURST, [79:61] reserved (ignored)
ar_valid  input  1  request valid
ar_ready  output  1  request accepted when ar_valid & ar_ready
m_axi_arid  output  4  AXI ARID
m_axi_araddr  output  48  AXI ARADDR
m_axi_arlen  output  8  AXI ARLEN
m_axi_arsize  output  3  AXI ARSIZE
m_axi_arburst  output  2  AXI ARBURST
m_axi_arvalid  output  1  AXI ARVALID
m_axi_arready  input  1  AXI ARREADY
m_axi_rvalid  input  1  observed R valid (monitor only)
m_axi_rready  input  1  observed R ready (monitor only)
m_axi_rlast  input  1  observed R last (monitor only)
outstanding  output  8  current count of outstanding AXI reads
err_underflow  output  1  sticky: rlast handshake seen while outstanding==0

Behaviour:
- Reset (reset_n=0, async): state=IDLE, all m_axi_* outputs 0, ar_ready=0, outstanding=0, err_underflow=0. Any request held mid-operation is dropped.
- ar_ready = reset_n & (state==IDLE).
- States: IDLE, HOLD_A, SEND_A, HOLD_B, SEND_B.
- IDLE, on accept: register the fields.
  - Go to SEND_A if outstanding < MAX_OUTSTANDING, else HOLD_A.
  - Latency: accept at cycle N gives m_axi_arvalid=1 at N+1 (credit permitting).
- HOLD_x: arvalid=0. Move to SEND_x the cycle after outstanding < MAX_OUTSTANDING is seen.
- SEND_x: arvalid=1; all AR outputs held stable until arready.
  - On handshake in SEND_A: go to HOLD_B if split, else IDLE.
  - On handshake in SEND_B: go to IDLE.
  - arvalid never drops without a handshake.
- Split rule:
  - bytes = (ARLEN+1) << ARSIZE, room = 4096 - ARADDR[11:0].
  - Split only if ARBURST==2'b01 (INCR) and bytes > room.
  - Piece A: original address, ARLEN_A = (room >> ARSIZE) - 1.
  - Piece B: address = (ARADDR | 12'hFFF) + 1, ARLEN_B = ARLEN - ARLEN_A - 1.
  - ID, SIZE and BURST are copied to both pieces.
- FIXED/WRAP/reserved bursts: never split; passed through unchanged.
- ARSIZE > 4 is passed through unsplit; no check is made.
- Credit counter:
  - +1 on m_axi_arvalid & m_axi_arready.
  - -1 on m_axi_rvalid & m_axi_rready & m_axi_rlast.
  - Both in the same cycle: unchanged.
  - Decrement at 0: counter stays 0 and err_underflow is set (cleared only by reset).
- Counter width is 8 bits; it never exceeds MAX_OUTSTANDING by construction.

Optional Feature:
AR_ISSUE_STATS_EN
- Defined: adds output ports stat_issued[31:0] and stat_split[31:0], both reset to 0.
  - stat_issued: +1 per AXI AR handshake.
  - stat_split: +1 per accepted request that splits.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Non-crossing INCR: ar addr 0x0000_1000_0000, len 15, size 4 accepted at N -> one AR at N+1, araddr 0x0000_1000_0000, arlen 15; outstanding becomes 1.
- 4 KB crossing: addr 0x0000_1000_0F80, len 15, size 4 -> AR#1 addr 0x...0F80 arlen 7, then AR#2 addr 0x0000_1000_1000 arlen 7; ar_ready low until AR#2 handshake.
- Credit limit (MAX_OUTSTANDING=2): three non-crossing requests with no R traffic -> two ARs issued, third held in HOLD_A with arvalid=0; one rlast handshake -> third AR issued on the following cycle.
- Backpressure: arready held 0 for 5 cycles -> arvalid stays 1 and araddr/arlen stay stable; ar_ready stays 0.
- Simultaneous events: AR handshake and rlast handshake in the same cycle with outstanding=1 -> outstanding remains 1. Spurious rlast with outstanding=0 -> err_underflow=1 and outstanding=0.
- Async reset asserted in SEND_B -> arvalid=0 immediately; after release, state IDLE, ar_ready=1, outstanding=0.
